// File: rtl/itag_sweep_banks_pkg.sv
// Shared types for the itag_sweep_banks tag array: entry layout, FSM states
// and the address-split width helpers used by the top and the tag banks.
package itag_sweep_banks_pkg;

  // Widest tag any legal geometry produces (LINE_W >= 4, LINES >= 2).
  localparam int TAG_MAX_W = 29;

  // Unpacked view of one stored entry; the tag is zero-extended to TAG_MAX_W.
  typedef struct packed {
    logic                 par;
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } itag_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_w);
    return 32 - off_w(line_w) - idx_w(lines);
  endfunction

  // Round-robin pointer width; a single-way array still keeps one bit.
  function automatic int ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/itag_sweep_banks_tag_bank.sv
// One way of the tag array: simple dual-port RAM, port A registered read,
// port B write. Read returns the old contents on a same-address write.
module itag_sweep_banks_tag_bank
  import itag_sweep_banks_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 23,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write storage array.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/itag_sweep_banks.sv
// itag_sweep_banks: set-associative instruction tag array with a two-stage
// lookup (read at stage1, compare at stage2), round-robin fill, invalidate
// and a one-line-per-cycle flush sweep that also runs after reset.
// Optional feature: define ITAG_PARITY_EN to store an even-parity bit per
// entry; a bad entry misses, pulses parity_err and is cleared.
module itag_sweep_banks
  import itag_sweep_banks_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int LINES  = 64,
  parameter int LINE_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     stage1_addr,
  input  logic            stage1_adv,
  input  logic [31:0]     stage2_addr,
  input  logic            update,
  input  logic            invalidate,
  input  logic            flush,
  output logic            tag_hit,
  output logic [WAYS-1:0] tag_hit_way,
  output logic [WAYS-1:0] victim_way,
  output logic            busy,
  output logic            parity_err
);

  localparam int OFF_W = off_w(LINE_W);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, LINE_W);
  localparam int PTR_W = ptr_w(WAYS);
`ifdef ITAG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENTRY_W = TAG_W + 1 + PAR_W;

  sweep_state_t      state;
  logic [IDX_W-1:0]  sweep_cnt;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              lookup_q;
  logic              busy_int;

  logic [IDX_W-1:0]  s1_idx;
  logic [IDX_W-1:0]  s2_idx;
  logic [TAG_W-1:0]  s2_tag;
  logic              rd_en;
  logic              upd_act;
  logic              inv_act;

  logic [PTR_W-1:0]  ptr [LINES];
  logic [PTR_W-1:0]  ptr_next;

  logic [ENTRY_W-1:0] rd_word [WAYS];
  logic [ENTRY_W-1:0] wr_data [WAYS];
  logic [IDX_W-1:0]   wr_addr [WAYS];
  logic [WAYS-1:0]    wr_en;
  logic [ENTRY_W-1:0] upd_word;

  itag_entry_t       rd_e [WAYS];
  logic [WAYS-1:0]   match;
  logic [WAYS-1:0]   perr;
  logic              unused_par;
  logic              unused_addr;

  assign s1_idx = stage1_addr[OFF_W +: IDX_W];
  assign s2_idx = stage2_addr[OFF_W +: IDX_W];
  assign s2_tag = stage2_addr[31 -: TAG_W];
  assign unused_addr = ^{stage1_addr[31 -: TAG_W], stage1_addr[OFF_W-1:0],
                         stage2_addr[OFF_W-1:0]};

  assign busy_int = (state == ST_SWEEP);
  assign busy     = busy_int;
  assign rd_en    = stage1_adv && !busy_int;
  assign inv_act  = rst_n && invalidate && !busy_int;
  assign upd_act  = rst_n && update && !invalidate && !busy_int;

`ifdef ITAG_PARITY_EN
  assign upd_word = {^{1'b1, s2_tag}, 1'b1, s2_tag};
`else
  assign upd_word = {1'b1, s2_tag};
`endif

  assign victim_way = WAYS'(1) << ptr[s2_idx];
  assign ptr_next   = (WAYS == 1) ? '0 : ptr[s2_idx] + PTR_W'(1);

  // Sweep FSM plus the stage1->stage2 lookup pipeline flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SWEEP;
      sweep_cnt <= '0;
      lookup_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      lookup_q <= rd_en;
      if (rd_en) rd_idx_q <= s1_idx;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
          end
        end
        ST_SWEEP: begin
          sweep_cnt <= sweep_cnt + IDX_W'(1);
          if (sweep_cnt == IDX_W'(LINES - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-line round-robin victim pointers: cleared by the sweep, bumped by fills.
  always_ff @(posedge clk) begin
    if (busy_int) ptr[sweep_cnt] <= '0;
    else if (upd_act) ptr[s2_idx] <= ptr_next;
  end

  // Unpack read data, parity check and tag compare against stage2.
  always_comb begin
    unused_par = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      rd_e[w]       = '0;
      rd_e[w].tag   = TAG_MAX_W'(rd_word[w][TAG_W-1:0]);
      rd_e[w].valid = rd_word[w][TAG_W];
`ifdef ITAG_PARITY_EN
      rd_e[w].par   = rd_word[w][ENTRY_W-1];
      perr[w]       = lookup_q & (^rd_e[w]);
`else
      perr[w]       = 1'b0;
      unused_par    = unused_par ^ rd_e[w].par;
`endif
      match[w] = lookup_q & rd_e[w].valid & ~perr[w] &
                 (rd_e[w].tag == TAG_MAX_W'(s2_tag));
    end
  end

  // Write-port arbitration per way: sweep, invalidate, parity scrub, fill.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      wr_en[w]   = 1'b0;
      wr_addr[w] = s2_idx;
      wr_data[w] = upd_word;
      if (busy_int) begin
        wr_en[w]   = 1'b1;
        wr_addr[w] = sweep_cnt;
        wr_data[w] = '0;
      end else if (inv_act && match[w]) begin
        wr_en[w]   = 1'b1;
        wr_data[w] = '0;
      end else if (perr[w]) begin
        wr_en[w]   = 1'b1;
        wr_addr[w] = rd_idx_q;
        wr_data[w] = '0;
      end else if (upd_act && victim_way[w]) begin
        wr_en[w]   = 1'b1;
      end
    end
  end

  assign tag_hit_way = match & {WAYS{~invalidate}};
  assign tag_hit     = |tag_hit_way;
  assign parity_err  = |perr;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    itag_sweep_banks_tag_bank #(
      .DEPTH(LINES),
      .WIDTH(ENTRY_W)
    ) u_tag_bank (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_addr (s1_idx),
      .rd_data (rd_word[w]),
      .wr_en   (wr_en[w]),
      .wr_addr (wr_addr[w]),
      .wr_data (wr_data[w])
    );
  end

endmodule

// File: tb/tb_itag_sweep_banks.sv
// Bench for itag_sweep_banks (WAYS=4, LINES=64, LINE_W=16): directed lookups
// push expected hit vectors into a queue; a monitor pops one per compare cycle.
// Line index = addr[9:4], tag = addr[31:10].
module tb_itag_sweep_banks;

  logic        clk;
  logic        rst_n;
  logic [31:0] stage1_addr;
  logic        stage1_adv;
  logic [31:0] stage2_addr;
  logic        update;
  logic        invalidate;
  logic        flush;
  logic        tag_hit;
  logic [3:0]  tag_hit_way;
  logic [3:0]  victim_way;
  logic        busy;
  logic        parity_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  way;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   runs[$];
  int   vectors     = 0;
  int   miscompares = 0;

  itag_sweep_banks #(.WAYS(4), .LINES(64), .LINE_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stage1_addr (stage1_addr),
    .stage1_adv  (stage1_adv),
    .stage2_addr (stage2_addr),
    .update      (update),
    .invalidate  (invalidate),
    .flush       (flush),
    .tag_hit     (tag_hit),
    .tag_hit_way (tag_hit_way),
    .victim_way  (victim_way),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a lookup; the second cycle optionally carries invalidate/update/flush.
  task automatic lookup(input logic [31:0] addr, input logic [3:0] way, input logic perr,
                        input logic inv, input logic upd, input logic fl);
    stage1_addr = addr;
    stage1_adv  = 1'b1;
    exp_q.push_back('{addr: addr, way: way, perr: perr});
    tick();
    stage1_adv  = 1'b0;
    stage2_addr = addr;
    invalidate  = inv;
    update      = upd;
    flush       = fl;
    tick();
    invalidate  = 1'b0;
    update      = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [3:0] exp_victim);
    stage2_addr = addr;
    #1;
    chk($sformatf("victim %h", addr), victim_way, exp_victim);
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (busy !== 1'b0) chk({name, " timeout"}, busy, 0);
    tick();
    if (runs.size() == 0) chk({name, " no busy run"}, 0, 64);
    else chk({name, " busy cycles"}, runs.pop_front(), 64);
  endtask

  // Scoreboard monitor: a lookup sampled at a posedge is checked mid next cycle.
  initial begin : monitor
    logic lk;
    exp_t e;
    forever begin
      @(posedge clk);
      lk = stage1_adv;
      @(negedge clk);
      if (lk) begin
        if (exp_q.size() == 0) begin
          chk("lookup without expectation", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("lookup %h {hit,way,perr}", e.addr),
              {26'b0, tag_hit, tag_hit_way, parity_err},
              {26'b0, |e.way, e.way, e.perr});
        end
      end
    end
  end

  // Measures each busy-high run (out of reset) in clock cycles.
  initial begin : busy_runs
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) run = 0;
      else if (busy === 1'b1) run++;
      else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin : stim
    rst_n       = 1'b0;
    stage1_addr = '0;
    stage1_adv  = 1'b0;
    stage2_addr = '0;
    update      = 1'b0;
    invalidate  = 1'b0;
    flush       = 1'b0;

    // Reset: outputs quiet, sweep pending, 64 busy cycles, lookups miss.
    @(posedge clk);
    @(negedge clk);
    chk("reset tag_hit_way", tag_hit_way, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset busy", busy, 1);
    tick();
    rst_n = 1'b1;
    lookup(32'h0000_1230, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("reset sweep");

    // Basic fill and hit.
    fill(32'h0000_1230, 4'b0001);
    lookup(32'h0000_1230, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush in the compare cycle of a hit; mid-sweep flush ignored.
    lookup(32'h0000_1230, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("flush sweep");
    chk("hit after sweep", tag_hit_way, 0);
    lookup(32'h0000_1230, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Five fills to line 0x23: round-robin wraps, first tag evicted.
    fill(32'h0000_0630, 4'b0001);
    fill(32'h0000_0A30, 4'b0010);
    fill(32'h0000_0E30, 4'b0100);
    fill(32'h0000_1230, 4'b1000);
    fill(32'h0000_1630, 4'b0001);
    lookup(32'h0000_0630, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1630, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0A30, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1230, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Invalidate + update together: invalidate wins, pointer stays at way1.
    lookup(32'h0000_0A30, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    stage2_addr = 32'h0000_0A30;
    #1;
    chk("victim after inv+upd", victim_way, 4'b0010);
    lookup(32'h0000_0A30, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0E30, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill in the compare cycle of its own lookup: no bypass.
    lookup(32'h0000_1A30, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    lookup(32'h0000_1A30, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

    // Plain invalidate of a hit, and invalidate of a miss is a no-op.
    lookup(32'h0000_1630, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_1630, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_2230, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    lookup(32'h0000_0E30, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1230, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Boundary lines 0 and 63; same index with another tag misses.
    fill(32'h0000_0000, 4'b0001);
    fill(32'h0000_03F0, 4'b0001);
    lookup(32'h0000_0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_03F0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0400, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ITAG_PARITY_EN
    // Corrupt way2 of line 5: one-cycle parity_err, forced miss, entry scrubbed.
    fill(32'h0000_0450, 4'b0001);
    fill(32'h0000_0850, 4'b0010);
    fill(32'h0000_0C50, 4'b0100);
    lookup(32'h0000_0C50, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    dut.g_way[2].u_tag_bank.mem[5][0] = ~dut.g_way[2].u_tag_bank.mem[5][0];
    lookup(32'h0000_0C50, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0C50, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_0850, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (3) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/itag_sweep_banks.md
ITAG_SWEEP_BANKS -- requirements
Module: itag_sweep_banks

Interface
REQ-001 SHALL have parameter WAYS, 4, number of ways (1..8, power of two).
REQ-002 SHALL have parameter LINES, 64, lines per way (power of two, >=2).
REQ-003 SHALL have parameter LINE_W, 16, bytes per cache line (power of two, >=4).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stage1_addr  input  32  lookup address, read cycle.
REQ-007 SHALL have port stage1_adv  input  1  start lookup of stage1_addr.
REQ-008 SHALL have port stage2_addr  input  32  address compared, updated or invalidated.
REQ-009 SHALL have port update  input  1  fill: write stage2 tag into victim way.
REQ-010 SHALL have port invalidate  input  1  clear stage2 line in the hitting way.
REQ-011 SHALL have port flush  input  1  request a full-array invalidate sweep.
REQ-012 SHALL have port tag_hit  output  1  OR of tag_hit_way.
REQ-013 SHALL have port tag_hit_way  output  WAYS  one-hot hit vector.
REQ-014 SHALL have port victim_way  output  WAYS  one-hot way the next update writes.
REQ-015 SHALL have port busy  output  1  sweep in progress; lookups forced to miss.
REQ-016 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch (see REQ-032).

Function
REQ-017 SHALL derive TAG_W = 32 - log2(LINE_W) - log2(LINES); line index = addr[log2(LINE_W) +: log2(LINES)].
REQ-018 SHALL store per way per line one valid bit plus TAG_W tag bits.
REQ-019 SHALL read all ways at stage1 index when stage1_adv=1 and busy=0; result valid exactly one cycle later.
REQ-020 SHALL assert tag_hit_way[i] only when previous cycle had stage1_adv=1 and busy=0, way i valid, stored tag equals stage2_addr tag, invalidate=0.
REQ-021 SHALL, on update=1 and busy=0, write {valid=1, stage2 tag} into victim_way at stage2 index.
REQ-022 SHALL, on invalidate=1 and busy=0, clear valid in every way whose tag matched in that cycle; no-op on miss.
REQ-023 SHALL give invalidate priority over update when both asserted in the same cycle; update dropped.
REQ-024 SHALL keep per-line round-robin pointer (log2(WAYS) bits); victim_way decodes pointer of stage2 index; pointer increments modulo WAYS on each accepted update only.
REQ-025 SHALL implement FSM IDLE/SWEEP: IDLE->SWEEP on flush=1; SWEEP clears valid and pointer of line counter index in all ways, one line per cycle, counter 0..LINES-1; SWEEP->IDLE after line LINES-1.
REQ-026 SHALL hold busy=1 for exactly LINES cycles per sweep.
REQ-027 SHALL ignore flush while in SWEEP (no restart, no extension).
REQ-028 SHALL ignore stage1_adv, update and invalidate while busy=1; tag_hit_way=0 the cycle after busy falls unless a new lookup started.
REQ-029 SHALL return a hit for a lookup whose stage2 cycle coincides with an update to the same line and way only from the next lookup onward (no write-to-read bypass).

Reset
REQ-030 SHALL, on rst_n=0, set tag_hit_way=0, parity_err=0, counter=0 and enter SWEEP; busy=1 for LINES cycles following rst_n deassertion; rst_n=0 during a sweep restarts it at line 0.

Configuration
REQ-031 SHALL use macro ITAG_PARITY_EN.
REQ-032 SHALL, with ITAG_PARITY_EN defined, store one even-parity bit over {valid, tag} per entry; mismatch on read forces that way to miss, pulses parity_err the compare cycle, and clears that entry's valid the same cycle.
REQ-033 SHALL, without ITAG_PARITY_EN, store no parity bit and tie parity_err to 0.

Structure
REQ-034 SHALL place itag_entry_t typedef, TAG_W/index-width derivation functions and the FSM state enum in the shared types package.
REQ-035 SHALL instantiate per way one tag_bank dual-port RAM sub-module (port A read, port B write); pointers and FSM in flops in this module.

Verification
REQ-036 Reset, WAYS=4, LINES=64: rst_n low 2 cycles -> busy=1 exactly 64 cycles, every lookup misses.
REQ-037 update addr 0x0000_1230 (victim way0), then lookup 0x0000_1230 -> tag_hit_way=4'b0001 one cycle after stage1_adv.
REQ-038 Five updates to line 0x23 with distinct tags -> victim sequence 0001,0010,0100,1000,0001; first tag misses afterwards.
REQ-039 flush while lookup of cached 0x0000_1230 pending -> busy 64 cycles, second flush mid-sweep ignored, subsequent lookup misses.
REQ-040 invalidate and update same cycle on hitting line -> entry invalid, pointer unchanged, next lookup misses.
REQ-041 ITAG_PARITY_EN: force one tag bit flip in way2 -> parity_err one cycle, tag_hit_way[2]=0, repeat lookup misses, parity_err=0.
